time_counter: RTL and testbench
===============================

Name: time_counter

Overview:
- Downstream stage of the time-setting block: captures user-set hours/minutes/seconds on a load strobe, then keeps running time of day.
- Counts 00:00:00 to 23:59:59 from an internal prescaler that divides the system clock to a 1 Hz tick.
- Outputs feed the display/BCD stage; status pulses are available to alarm logic.

Parameters:
- TICK_DIV, 100000000, system-clock cycles per one-second tick; must be >= 2. Bench uses 4.
- PRESCALE_W, 27, prescaler width; must satisfy 2^PRESCALE_W >= TICK_DIV.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- load  in  1  single-cycle strobe; capture set_* values
- set_hours  in  8  binary hours to load, valid 0..23
- set_minutes  in  8  binary minutes to load, valid 0..59
- set_seconds  in  8  binary seconds to load, valid 0..59
- run_en  in  1  level; 1 = count, 0 = pause
- hours  out  8  current hours, binary 0..23
- minutes  out  8  current minutes, binary 0..59
- seconds  out  8  current seconds, binary 0..59
- sec_tick  out  1  1-cycle pulse, high in the cycle the new seconds value is first visible
- day_wrap  out  1  1-cycle pulse, coincident with sec_tick, when time rolls 23:59:59 -> 00:00:00
- load_err  out  1  1-cycle pulse when a load is rejected
- pm  out  1  present only with HOUR12_EN (see Optional Feature)

Behaviour:
- Clock is one clk; reset is synchronous and active-high.
- Reset: hours=minutes=seconds=0, prescaler=0, FSM=STOPPED, sec_tick=day_wrap=load_err=0.
- Priority on any edge: reset > load > tick.
- FSM states:
  - STOPPED -> RUNNING when run_en=1.
  - RUNNING -> STOPPED when run_en=0.
  - The state change takes effect at the edge that samples run_en.
- Prescaler:
  - Increments only in RUNNING.
  - Holds its value in STOPPED, so pause/resume does not lose a partial second.
  - At TICK_DIV-1 it wraps to 0 and generates a tick.
- Tick increments seconds:
  - seconds 59 -> 0 and minutes +1.
  - minutes 59 -> 0 and hours +1.
  - hours 23 -> 0 and day_wrap asserts.
- Output timing:
  - Outputs are registered; the new values appear one clk after the terminal prescaler count.
  - sec_tick and day_wrap are registered and align with the new values.
- Load, valid case (set_hours<=23, set_minutes<=59, set_seconds<=59):
  - All three are captured at that edge and the prescaler clears to 0.
  - First tick after load occurs TICK_DIV RUNNING cycles later.
  - A tick due in the same cycle is discarded; no sec_tick.
  - FSM state is unchanged by load.
- Load, invalid case (any field out of range):
  - Whole load is rejected; time and prescaler are unchanged.
  - load_err pulses for 1 cycle; the tick in that cycle proceeds normally.
- Load while STOPPED is permitted; values hold until run_en=1.
- load held high for multiple cycles reloads every cycle; the prescaler stays at 0.
- Reset mid-count discards all state, including a pending pulse.
- All arithmetic is 8-bit unsigned; no value outside the stated ranges is ever produced.

Optional Feature:
- Macro: TIME_COUNTER_HOUR12_EN.
- When defined:
  - Adds output pm.
  - hours presents 12-hour format: internal 0 -> 12 with pm=0; 1..11 -> same with pm=0; 12 -> 12 with pm=1; 13..23 -> 1..11 with pm=1.
  - The internal count, load inputs and load validation remain 24-hour.
  - The conversion is registered with the same latency as the other outputs.
- When undefined: no pm port; hours is 24-hour binary.

Test Plan:
- Reset, then run_en=1 for 12 cycles (TICK_DIV=4) -> seconds=3, exactly three sec_tick pulses, 4 cycles apart.
- Load 23:59:58, run -> after 4 cycles 23:59:59; after 8 cycles 00:00:00 with sec_tick=day_wrap=1 in the same cycle.
- Load 10:24:60 -> load_err=1 for one cycle, time unchanged at 00:00:00; load 10:24:59 -> 10:24:59, no load_err.
- Run 2 cycles, run_en=0 for 10 cycles, run_en=1 -> first sec_tick 2 running cycles after resume; seconds unchanged during pause.
- Load 05:00:00 in the cycle the prescaler hits 3 -> time=05:00:00, no sec_tick; next tick 4 cycles later -> 05:00:01.
- With TIME_COUNTER_HOUR12_EN: load 00:00:00 -> hours=12, pm=0; load 13:05:00 -> hours=1, pm=1; load 12:00:00 -> hours=12, pm=1.

Source files
------------

// File: rtl/time_counter_if.sv
// Signal bundle between the time-setting block and the time-of-day counter.
// master = side that drives load/set/run controls, slave = the counter itself.
// With TIME_COUNTER_HOUR12_EN defined the bundle also carries the pm flag.
interface time_counter_if;
    logic       load;
    logic [7:0] set_hours;
    logic [7:0] set_minutes;
    logic [7:0] set_seconds;
    logic       run_en;
    logic [7:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic       sec_tick;
    logic       day_wrap;
    logic       load_err;
`ifdef TIME_COUNTER_HOUR12_EN
    logic       pm;
`endif

    modport master (
        output load, set_hours, set_minutes, set_seconds, run_en,
        input  hours, minutes, seconds, sec_tick, day_wrap, load_err
`ifdef TIME_COUNTER_HOUR12_EN
        , input pm
`endif
    );

    modport slave (
        input  load, set_hours, set_minutes, set_seconds, run_en,
        output hours, minutes, seconds, sec_tick, day_wrap, load_err
`ifdef TIME_COUNTER_HOUR12_EN
        , output pm
`endif
    );
endinterface

// File: rtl/time_counter.sv
// Time-of-day counter 00:00:00..23:59:59 driven by a 1 Hz tick divided
// down from clk. Captures a user-set time on a load strobe; rejects
// out-of-range loads with a load_err pulse.
// Optional macro TIME_COUNTER_HOUR12_EN: hours is presented in 12-hour
// form with a pm flag; the internal count stays 24-hour.
module time_counter #(
    parameter int TICK_DIV   = 100000000,
    parameter int PRESCALE_W = 27
) (
    input  logic          clk,
    input  logic          reset,
    time_counter_if.slave tc
);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICK_DIV - 1);
    localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);

    // Increment with wrap to zero after 'top'.
    function automatic logic [7:0] wrap_inc(input logic [7:0] value,
                                            input logic [7:0] top);
        return (value == top) ? 8'd0 : value + 8'd1;
    endfunction

`ifdef TIME_COUNTER_HOUR12_EN
    // 24-hour value to {pm, 12-hour value}; midnight shows as 12 am.
    function automatic logic [8:0] to_12h(input logic [7:0] h24);
        if (h24 == 8'd0)
            return {1'b0, 8'd12};
        else if (h24 < 8'd12)
            return {1'b0, h24};
        else if (h24 == 8'd12)
            return {1'b1, 8'd12};
        else
            return {1'b1, h24 - 8'd12};
    endfunction
`endif

    state_t                  state_q, state_d;
    logic                    counting;
    logic                    load_ok;
    logic                    tick;

    logic [PRESCALE_W-1:0]   presc_p0, presc_p1;
    logic [7:0]              hours_p0, hours_p1;
    logic [7:0]              minutes_p0, minutes_p1;
    logic [7:0]              seconds_p0, seconds_p1;
    logic                    vld_p0, vld_p1;
    logic                    wrap_p0, wrap_p1;
    logic                    err_p0, err_p1;
`ifdef TIME_COUNTER_HOUR12_EN
    logic [8:0]              disp_p0;
    logic [7:0]              disp_hours_p1;
    logic                    pm_p1;
`endif

    // Run/pause FSM next state: follows run_en at the sampling edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STOPPED: if (tc.run_en)  state_d = RUNNING;
            RUNNING: if (!tc.run_en) state_d = STOPPED;
            default: state_d = STOPPED;
        endcase
    end

    // Next-time computation: load beats tick; a rejected load leaves the
    // count alone and only raises load_err.
    always_comb begin
        counting = (state_d == RUNNING);
        load_ok  = tc.load
                   && (tc.set_hours   <= 8'd23)
                   && (tc.set_minutes <= 8'd59)
                   && (tc.set_seconds <= 8'd59);
        tick     = counting && (presc_p1 == PRESC_LAST);

        presc_p0   = presc_p1;
        hours_p0   = hours_p1;
        minutes_p0 = minutes_p1;
        seconds_p0 = seconds_p1;
        vld_p0     = 1'b0;
        wrap_p0    = 1'b0;
        err_p0     = tc.load && !load_ok;

        if (load_ok) begin
            // Prescaler restarts so the first tick is a full second away;
            // a tick due this cycle is dropped.
            presc_p0   = '0;
            hours_p0   = tc.set_hours;
            minutes_p0 = tc.set_minutes;
            seconds_p0 = tc.set_seconds;
        end else if (counting) begin
            if (tick) begin
                presc_p0   = '0;
                vld_p0     = 1'b1;
                seconds_p0 = wrap_inc(seconds_p1, 8'd59);
                if (seconds_p1 == 8'd59) begin
                    minutes_p0 = wrap_inc(minutes_p1, 8'd59);
                    if (minutes_p1 == 8'd59) begin
                        hours_p0 = wrap_inc(hours_p1, 8'd23);
                        wrap_p0  = (hours_p1 == 8'd23);
                    end
                end
            end else begin
                presc_p0 = presc_p1 + PRESC_ONE;
            end
        end

`ifdef TIME_COUNTER_HOUR12_EN
        disp_p0 = to_12h(hours_p0);
`endif
    end

    // ---- stage p0 -> p1: state, prescaler, time and pulse registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= STOPPED;
            presc_p1      <= '0;
            hours_p1      <= 8'd0;
            minutes_p1    <= 8'd0;
            seconds_p1    <= 8'd0;
            vld_p1        <= 1'b0;
            wrap_p1       <= 1'b0;
            err_p1        <= 1'b0;
`ifdef TIME_COUNTER_HOUR12_EN
            disp_hours_p1 <= 8'd12;
            pm_p1         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            presc_p1      <= presc_p0;
            hours_p1      <= hours_p0;
            minutes_p1    <= minutes_p0;
            seconds_p1    <= seconds_p0;
            vld_p1        <= vld_p0;
            wrap_p1       <= wrap_p0;
            err_p1        <= err_p0;
`ifdef TIME_COUNTER_HOUR12_EN
            disp_hours_p1 <= disp_p0[7:0];
            pm_p1         <= disp_p0[8];
`endif
        end
    end

`ifdef TIME_COUNTER_HOUR12_EN
    assign tc.hours = disp_hours_p1;
    assign tc.pm    = pm_p1;
`else
    assign tc.hours = hours_p1;
`endif
    assign tc.minutes  = minutes_p1;
    assign tc.seconds  = seconds_p1;
    assign tc.sec_tick = vld_p1;
    assign tc.day_wrap = wrap_p1;
    assign tc.load_err = err_p1;

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: directed scenarios followed by random traffic,
// every cycle compared against a seconds-of-day reference model.
module tb_time_counter;

    localparam int TICK_DIV = 4;
    localparam int DAY_SECS = 24 * 3600;

    logic clk = 1'b0;
    logic reset;
    time_counter_if tc();

    time_counter #(
        .TICK_DIV   (TICK_DIV),
        .PRESCALE_W (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tc    (tc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    // Reference model: time as seconds since midnight plus prescaler phase.
    int m_tod = 0;
    int m_pre = 0;
    bit m_tick, m_wrap, m_err;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
    endtask

    // Drive one cycle of inputs, advance model, compare all outputs.
    task automatic step(input bit rst, input bit ld, input int h, input int m,
                        input int s, input bit run);
        int eh;
        reset          = rst;
        tc.load        = ld;
        tc.set_hours   = 8'(h);
        tc.set_minutes = 8'(m);
        tc.set_seconds = 8'(s);
        tc.run_en      = run;
        @(posedge clk);
        #1;
        cycle++;

        m_tick = 0; m_wrap = 0; m_err = 0;
        if (rst) begin
            m_tod = 0;
            m_pre = 0;
        end else if (ld && h <= 23 && m <= 59 && s <= 59) begin
            m_tod = h * 3600 + m * 60 + s;
            m_pre = 0;
        end else begin
            m_err = ld;
            if (run) begin
                if (m_pre == TICK_DIV - 1) begin
                    m_pre  = 0;
                    m_tod  = (m_tod + 1) % DAY_SECS;
                    m_tick = 1;
                    m_wrap = (m_tod == 0);
                end else begin
                    m_pre++;
                end
            end
        end

        eh = m_tod / 3600;
`ifdef TIME_COUNTER_HOUR12_EN
        check("pm", int'(tc.pm), (eh >= 12) ? 1 : 0);
        eh = (eh % 12 == 0) ? 12 : eh % 12;
`endif
        check("hours",    int'(tc.hours),    eh);
        check("minutes",  int'(tc.minutes),  (m_tod / 60) % 60);
        check("seconds",  int'(tc.seconds),  m_tod % 60);
        check("sec_tick", int'(tc.sec_tick), int'(m_tick));
        check("day_wrap", int'(tc.day_wrap), int'(m_wrap));
        check("load_err", int'(tc.load_err), int'(m_err));
    endtask

    task automatic run_cycles(input int n, input bit run);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, run);
    endtask

    initial begin
        int ticks;
        int last_tick;
        reset = 1'b1;
        tc.load = 1'b0;
        tc.set_hours = '0;
        tc.set_minutes = '0;
        tc.set_seconds = '0;
        tc.run_en = 1'b0;

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        check("rst_seconds", int'(tc.seconds), 0);
        check("rst_sec_tick", int'(tc.sec_tick), 0);

        // Free run 12 cycles: three ticks, 4 cycles apart
        ticks = 0;
        last_tick = -1;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0, 1);
            if (tc.sec_tick) begin
                if (last_tick >= 0) check("tick_gap", cycle - last_tick, TICK_DIV);
                last_tick = cycle;
                ticks++;
            end
        end
        check("run12_ticks", ticks, 3);
        check("run12_seconds", int'(tc.seconds), 3);

        // Day rollover
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 23, 59, 58, 1);
        run_cycles(4, 1);
        check("roll_sec59", int'(tc.seconds), 59);
        run_cycles(4, 1);
        check("roll_sec0", int'(tc.seconds), 0);
        check("roll_day_wrap", int'(tc.day_wrap), 1);
        check("roll_sec_tick", int'(tc.sec_tick), 1);

        // Invalid then valid load
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 10, 24, 60, 0);
        check("bad_load_err", int'(tc.load_err), 1);
        check("bad_load_min", int'(tc.minutes), 0);
        step(0, 0, 0, 0, 0, 0);
        check("bad_load_err_clr", int'(tc.load_err), 0);
        step(0, 1, 10, 24, 59, 0);
        check("good_load_min", int'(tc.minutes), 24);
        check("good_load_sec", int'(tc.seconds), 59);
        check("good_load_err", int'(tc.load_err), 0);

        // Pause keeps a partial second
        step(1, 0, 0, 0, 0, 0);
        run_cycles(2, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 0);
            check("pause_seconds", int'(tc.seconds), 0);
        end
        step(0, 0, 0, 0, 0, 1);
        check("resume_no_tick", int'(tc.sec_tick), 0);
        step(0, 0, 0, 0, 0, 1);
        check("resume_tick", int'(tc.sec_tick), 1);

        // Load colliding with terminal prescaler count
        step(1, 0, 0, 0, 0, 0);
        run_cycles(3, 1);
        step(0, 1, 5, 0, 0, 1);
        check("coll_no_tick", int'(tc.sec_tick), 0);
        check("coll_seconds", int'(tc.seconds), 0);
        run_cycles(3, 1);
        check("coll_wait", int'(tc.sec_tick), 0);
        step(0, 0, 0, 0, 0, 1);
        check("coll_tick", int'(tc.sec_tick), 1);
        check("coll_seconds1", int'(tc.seconds), 1);

`ifdef TIME_COUNTER_HOUR12_EN
        step(0, 1, 0, 0, 0, 0);
        check("h12_mid_hours", int'(tc.hours), 12);
        check("h12_mid_pm", int'(tc.pm), 0);
        step(0, 1, 13, 5, 0, 0);
        check("h12_13_hours", int'(tc.hours), 1);
        check("h12_13_pm", int'(tc.pm), 1);
        step(0, 1, 12, 0, 0, 0);
        check("h12_noon_hours", int'(tc.hours), 12);
        check("h12_noon_pm", int'(tc.pm), 1);
`endif

        // Random traffic, occasionally near rollover boundaries
        for (int i = 0; i < 3000; i++) begin
            bit r, l, run;
            int h, m, s;
            r   = ($urandom_range(0, 199) == 0);
            l   = ($urandom_range(0, 9) == 0);
            run = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1) begin
                h = $urandom_range(22, 23);
                m = 59;
                s = $urandom_range(55, 59);
            end else begin
                h = $urandom_range(0, 26);
                m = $urandom_range(0, 62);
                s = $urandom_range(0, 62);
            end
            step(r, l, h, m, s, run);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
